mux_arb_nto1: RTL
=================

MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

Interface
REQ-001 The block SHALL have parameter N, default 8: channel count, power of two, 2..32.
REQ-002 The block SHALL have parameter W, default 1: data width per channel.
REQ-003 The block SHALL have parameter MODE, default 0: 0 = fixed select on s, 1 = round-robin arbitration.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port i  input  N*W  packed channel data, channel k at i[k*W+W-1:k*W].
REQ-007 The block SHALL have port v  input  N  per-channel valid.
REQ-008 The block SHALL have port s  input  log2(N)  channel select, used only when MODE=0.
REQ-009 The block SHALL have port rdy  input  1  downstream ready.
REQ-010 The block SHALL have port y  output  W  registered selected data.
REQ-011 The block SHALL have port yv  output  1  y holds valid data.
REQ-012 The block SHALL have port ack  output  N  one-hot, one-cycle pulse to the channel whose data was captured.
REQ-013 The block SHALL have port g  output  log2(N)  index of the channel held in y.

Function
REQ-014 The block SHALL define load = (candidate exists) AND (yv=0 OR rdy=1), evaluated each rising edge.
REQ-015 MODE=0: the candidate SHALL be channel s, and only when v[s]=1.
REQ-016 MODE=1: the candidate SHALL be the first channel k with v[k]=1, searched from ptr+1 upward and wrapping modulo N through ptr.
REQ-017 On load, the block SHALL set y to the candidate data, yv=1, g to the candidate index, ack to the one-hot candidate for exactly that cycle, and ptr to the candidate index.
REQ-018 Latency SHALL be one cycle: data sampled at edge t SHALL appear on y after edge t.
REQ-019 When yv=1 and rdy=0, the block SHALL hold y, g and yv, and SHALL drive ack=0 (backpressure).
REQ-020 When there is no candidate and rdy=1, the block SHALL clear yv to 0 and SHALL hold y and g.
REQ-021 When yv=1, rdy=1 and a candidate exists in the same cycle, the block SHALL both consume the old word and load the new one, giving back-to-back throughput of 1 word/cycle.
REQ-022 ack SHALL be zero in every cycle without a load; at most one ack bit SHALL be set at a time.
REQ-023 Round-robin SHALL wrap: after granting channel N-1, the search SHALL start at channel 0.
REQ-024 MODE=1 with a single valid channel SHALL grant it on every load.
REQ-025 Changes to s or v while held under backpressure SHALL NOT affect y or g until the next load.

Reset
REQ-026 While rst=1, the block SHALL immediately force y=0, yv=0, ack=0, g=0 and ptr=N-1, so that channel 0 has first priority.
REQ-027 Assertion of rst mid-operation SHALL discard the held word without issuing ack.
REQ-028 On the first edge after rst deasserts, the block SHALL follow normal load rules.

Verification (N=8, W=4)
REQ-029 MODE=0: i=0x76543210, v=0xFF, rdy=1, sweep s=0..7 -> y follows s one cycle later (0..7), ack=1<<s, yv=1.
REQ-030 MODE=0: s=3, v=0xF7 -> yv=0 and ack=0 after the current word drains.
REQ-031 MODE=1: v=0xFF, rdy=1 held for 9 cycles -> g=0,1,...,7,0 and ack rotates 0x01..0x80,0x01.
REQ-032 MODE=1: v=0x24, rdy=1 -> g alternates 2,5,2,5; ack=0x04,0x20,...
REQ-033 Backpressure: yv=1, y=0x3, rdy=0 for 4 cycles while i and s change -> y=0x3, g unchanged, ack=0; then rdy=1 -> next load in the following cycle.
REQ-034 Reset mid-stream: assert rst asynchronously between edges with yv=1 -> y=0, yv=0, g=0 immediately; MODE=1 with v=0xFF after release -> first grant g=0.

Source files
------------

// File: rtl/mux_arb_nto1.sv
// N-to-1 registered mux/arbiter (fixed select or round-robin). One-cycle latency.
// The output word is held while downstream is not ready; a new word loads whenever the slot is empty or draining.
module mux_arb_nto1 #(
   parameter int N    = 8,
   parameter int W    = 1,
   parameter int MODE = 0,
   localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  i,
   input  logic [N-1:0]    v,
   input  logic [SW-1:0]   s,
   input  logic            rdy,
   output logic [W-1:0]    y,
   output logic            yv,
   output logic [N-1:0]    ack,
   output logic [SW-1:0]   g
);

   logic [W-1:0]  y_q,   y_d;
   logic          yv_q,  yv_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [SW-1:0] g_q,   g_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic          cand_vld;
   logic [SW-1:0] cand_idx;
   logic [SW-1:0] scan_idx;
   logic [W-1:0]  cand_dat;
   logic          load;

   // Round-robin scan starts just past the last grant and wraps through it.
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      scan_idx = '0;
      if (MODE == 0) begin
         cand_vld = v[s];
         cand_idx = s;
      end else begin
         for (int off = 1; off <= N; off++) begin
            scan_idx = ptr_q + SW'(off);
            if (!cand_vld && v[scan_idx]) begin
               cand_vld = 1'b1;
               cand_idx = scan_idx;
            end
         end
      end
   end

   assign cand_dat = i[cand_idx*W +: W];
   assign load     = cand_vld && (!yv_q || rdy);

   always_comb begin
      y_d   = y_q;
      yv_d  = yv_q;
      g_d   = g_q;
      ptr_d = ptr_q;
      ack_d = '0;
      if (load) begin
         y_d             = cand_dat;
         yv_d            = 1'b1;
         g_d             = cand_idx;
         ptr_d           = cand_idx;
         ack_d[cand_idx] = 1'b1;
      end else if (rdy) begin
         yv_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q   <= '0;
         yv_q  <= 1'b0;
         ack_q <= '0;
         g_q   <= '0;
         ptr_q <= SW'(N - 1);
      end else begin
         y_q   <= y_d;
         yv_q  <= yv_d;
         ack_q <= ack_d;
         g_q   <= g_d;
         ptr_q <= ptr_d;
      end
   end

   assign y   = y_q;
   assign yv  = yv_q;
   assign ack = ack_q;
   assign g   = g_q;

endmodule
